// File: rtl/cache_pkg.sv
// Shared types and default widths for the direct-mapped cache controller.
package cache_pkg;

    localparam int TAG_W_DEF   = 3;
    localparam int INDEX_W_DEF = 3;
    localparam int DATA_W_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MEM_READ   = 2'd1,
        WRITE_BACK = 2'd2
    } state_e;

endpackage

// File: rtl/cache_controller_if.sv
// CPU, cache-array and memory signals of the cache controller in one bundle.
interface cache_controller_if
    import cache_pkg::*;
#(
    parameter int TAG_W   = TAG_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
);

    // CPU side
    logic                     read;
    logic                     write;
    logic [31:0]              address;
    logic                     busywait;
    // cache-array side
    logic                     entry_valid;
    logic [TAG_W-1:0]         entry_tag;
    logic                     dirty;
    logic [DATA_W-1:0]        evict_data;
    logic [INDEX_W-1:0]       lookup_index;
    logic                     hit;
    logic                     fill;
    // memory side
    logic                     mem_Read;
    logic                     mem_Write;
    logic [TAG_W+INDEX_W-1:0] mem_Address;
    logic [DATA_W-1:0]        mem_Writedata;
    logic                     mem_BusyWait;

    modport slave (
        input  read, write, address, entry_valid, entry_tag, dirty, evict_data, mem_BusyWait,
        output busywait, lookup_index, hit, fill, mem_Read, mem_Write, mem_Address, mem_Writedata
    );

    modport master (
        output read, write, address, entry_valid, entry_tag, dirty, evict_data, mem_BusyWait,
        input  busywait, lookup_index, hit, fill, mem_Read, mem_Write, mem_Address, mem_Writedata
    );

endinterface

// File: rtl/cache_controller_tag_hit_unit.sv
// Hit detection: stored tag equals requested tag and the line is valid.
module tag_hit_unit
    import cache_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic [TAG_W-1:0] entry_tag_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic             entry_valid_i,
    output logic             hit_o
);

    assign hit_o = entry_valid_i && (entry_tag_i == req_tag_i);

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-back cache controller: hit detection, dirty write-back
// and block refill through a three-state FSM.
module cache_controller
    import cache_pkg::*;
#(
    parameter int TAG_W   = TAG_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input logic               clock,
    input logic               reset,
    cache_controller_if.slave bus
);

    state_e             state_q, state_d;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   req_tag;
    logic [DATA_W-1:0]  wb_data;
    logic               hit;
    logic               req;
    logic               unused_addr;

    assign index       = bus.address[INDEX_W+1:2];
    assign req_tag     = bus.address[TAG_W+INDEX_W+1:INDEX_W+2];
    assign unused_addr = ^{bus.address[31:TAG_W+INDEX_W+2], bus.address[1:0]};
    assign wb_data     = bus.evict_data;
    assign req         = bus.read | bus.write;

    tag_hit_unit #(.TAG_W(TAG_W)) u_tag_hit (
        .entry_tag_i   (bus.entry_tag),
        .req_tag_i     (req_tag),
        .entry_valid_i (bus.entry_valid),
        .hit_o         (hit)
    );

    assign bus.hit          = hit;
    assign bus.lookup_index = index;
    assign bus.busywait     = (state_q != IDLE) | (req & ~hit);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d           = state_q;
        bus.mem_Read      = 1'b0;
        bus.mem_Write     = 1'b0;
        bus.mem_Address   = '0;
        bus.mem_Writedata = '0;
        bus.fill          = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !hit) state_d = bus.dirty ? WRITE_BACK : MEM_READ;
            end
            WRITE_BACK: begin
                bus.mem_Write     = 1'b1;
                bus.mem_Address   = {bus.entry_tag, index};
                bus.mem_Writedata = wb_data;
                if (!bus.mem_BusyWait) state_d = MEM_READ;
            end
            MEM_READ: begin
                bus.mem_Read    = 1'b1;
                bus.mem_Address = {req_tag, index};
                // The array captures the block on the same edge the FSM returns to IDLE.
                if (!bus.mem_BusyWait) begin
                    bus.fill = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: the bench plays cache array and memory, and a line-level
// model predicts hits, write-backs, refills and stall length for every access.
module tb_cache_controller;

    localparam int TAG_W   = 3;
    localparam int INDEX_W = 3;
    localparam int DATA_W  = 32;
    localparam int NLINES  = 8;
    localparam int NBLK    = 64;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    cache_controller_if #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .DATA_W(DATA_W)) bus ();

    cache_controller #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model of the array contents and of main memory
    logic        v_m    [NLINES];
    logic [2:0]  t_m    [NLINES];
    logic        d_m    [NLINES];
    logic [31:0] data_m [NLINES];
    logic [31:0] mem_m  [NBLK];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic drive_array();
        logic [2:0] i;
        i = bus.address[4:2];
        bus.entry_valid = v_m[i];
        bus.entry_tag   = t_m[i];
        bus.dirty       = d_m[i];
        bus.evict_data  = data_m[i];
    endtask

    task automatic set_line(input int i, input bit v, input logic [2:0] t, input bit d, input logic [31:0] dat);
        v_m[i] = v; t_m[i] = t; d_m[i] = d; data_m[i] = dat;
    endtask

    // One CPU access, entered just after a falling edge; returns after a falling edge.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input int busy_cycles,
                          input bit drop, input string tag_name);
        logic [2:0]  idx, tg, old_tag;
        logic [31:0] old_data;
        logic [5:0]  wb_blk, rd_blk;
        bit exp_hit, exp_dirty, hit_now, done, fill_seen, exp_fill, exp_bw;
        int exp_stall, stall, fills, wr_cycles, rd_cycles, rd_starts, cnt, kind, prev_kind, k;
        idx = addr[4:2]; tg = addr[7:5];
        exp_hit   = v_m[idx] && (t_m[idx] == tg);
        exp_dirty = d_m[idx];
        old_tag   = t_m[idx];
        old_data  = data_m[idx];
        wb_blk    = {old_tag, idx};
        rd_blk    = {tg, idx};
        exp_stall = exp_hit ? 0 : (exp_dirty ? 1 + 2 * (busy_cycles + 1) : 2 + busy_cycles);
        bus.read = rd; bus.write = wr; bus.address = addr; bus.mem_BusyWait = 1'b1;
        drive_array();
        done = 0; stall = -1; fills = 0; wr_cycles = 0; rd_cycles = 0; rd_starts = 0;
        cnt = 0; prev_kind = 0; k = 0;
        while (!done && k < 60) begin
            #1;
            kind = bus.mem_Write ? 2 : (bus.mem_Read ? 1 : 0);
            if (kind != 0) begin
                if (kind != prev_kind) cnt = busy_cycles;
                if (cnt == 0) bus.mem_BusyWait = 1'b0;
                else begin bus.mem_BusyWait = 1'b1; cnt--; end
            end else bus.mem_BusyWait = 1'b1;
            if (kind == 1 && prev_kind != 1) rd_starts++;
            prev_kind = kind;
            #1;
            hit_now  = v_m[idx] && (t_m[idx] == tg);
            exp_fill = (kind == 1) && !bus.mem_BusyWait;
            exp_bw   = (kind != 0) || ((bus.read || bus.write) && !hit_now);
            tests_run++;
            if (bus.mem_Read && bus.mem_Write) begin
                tests_failed++; $display("FAIL %s read_and_write: both high at cycle %0d", tag_name, k);
            end
            tests_run++;
            if (bus.lookup_index !== idx) begin
                tests_failed++; $display("FAIL %s lookup_index: got %0h expected %0h", tag_name, bus.lookup_index, idx);
            end
            tests_run++;
            if (bus.hit !== hit_now) begin
                tests_failed++; $display("FAIL %s hit: got %0b expected %0b (cycle %0d)", tag_name, bus.hit, hit_now, k);
            end
            tests_run++;
            if (bus.busywait !== exp_bw) begin
                tests_failed++; $display("FAIL %s busywait: got %0b expected %0b (cycle %0d)", tag_name, bus.busywait, exp_bw, k);
            end
            tests_run++;
            if (bus.fill !== exp_fill) begin
                tests_failed++; $display("FAIL %s fill: got %0b expected %0b (cycle %0d)", tag_name, bus.fill, exp_fill, k);
            end
            if (kind == 2) begin
                wr_cycles++;
                tests_run++;
                if (bus.mem_Address !== wb_blk || bus.mem_Writedata !== old_data) begin
                    tests_failed++;
                    $display("FAIL %s writeback: got addr %0h data %0h expected addr %0h data %0h",
                             tag_name, bus.mem_Address, bus.mem_Writedata, wb_blk, old_data);
                end
                if (!bus.mem_BusyWait) mem_m[wb_blk] = old_data;
            end else if (kind == 1) begin
                rd_cycles++;
                tests_run++;
                if (bus.mem_Address !== rd_blk) begin
                    tests_failed++; $display("FAIL %s read_addr: got %0h expected %0h", tag_name, bus.mem_Address, rd_blk);
                end
            end else begin
                tests_run++;
                if (bus.mem_Address !== '0 || bus.mem_Writedata !== '0) begin
                    tests_failed++;
                    $display("FAIL %s idle_bus: got addr %0h data %0h expected 0 0", tag_name, bus.mem_Address, bus.mem_Writedata);
                end
            end
            if (bus.fill === 1'b1) fills++;
            if (!bus.busywait && kind == 0) begin
                done = 1; stall = k;
            end else begin
                fill_seen = (bus.fill === 1'b1);
                @(posedge clock); #1;
                if (fill_seen) set_line(idx, 1'b1, tg, 1'b0, mem_m[rd_blk]);
                if (drop && k == 0) begin bus.read = 1'b0; bus.write = 1'b0; end
                drive_array();
                @(negedge clock);
                k++;
            end
        end
        tests_run++;
        if (!done) begin
            tests_failed++; $display("FAIL %s timeout: busywait still %0b after %0d cycles", tag_name, bus.busywait, k);
        end
        tests_run++;
        if (stall != exp_stall) begin
            tests_failed++; $display("FAIL %s stall: got %0d expected %0d", tag_name, stall, exp_stall);
        end
        tests_run++;
        if (fills != (exp_hit ? 0 : 1) || rd_starts != (exp_hit ? 0 : 1)) begin
            tests_failed++; $display("FAIL %s fill_count: got fills %0d reads %0d expected %0d", tag_name, fills, rd_starts, exp_hit ? 0 : 1);
        end
        tests_run++;
        if (wr_cycles != ((!exp_hit && exp_dirty) ? busy_cycles + 1 : 0) ||
            rd_cycles != (exp_hit ? 0 : busy_cycles + 1)) begin
            tests_failed++; $display("FAIL %s mem_cycles: got wr %0d rd %0d", tag_name, wr_cycles, rd_cycles);
        end
        // The access completes on the next edge; a write marks the line dirty.
        @(posedge clock); #1;
        if (bus.write) begin d_m[idx] = 1'b1; data_m[idx] = $urandom; end
        bus.read = 1'b0; bus.write = 1'b0;
        drive_array();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        tests_run++;
        if (bus.mem_Read !== 1'b0 || bus.mem_Write !== 1'b0 || bus.fill !== 1'b0 || bus.busywait !== 1'b0 ||
            bus.mem_Address !== '0 || bus.mem_Writedata !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rd %0b wr %0b fill %0b bw %0b addr %0h expected all 0",
                     bus.mem_Read, bus.mem_Write, bus.fill, bus.busywait, bus.mem_Address);
        end
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_hit();
        set_line(1, 1'b1, 3'd1, 1'b0, 32'h1234_5678);
        access(1'b1, 1'b0, 32'h24, 0, 1'b0, "hit_0x24");
    endtask

    task automatic test_clean_miss();
        set_line(1, 1'b0, 3'd0, 1'b0, 32'h0);
        access(1'b1, 1'b0, 32'h24, 5, 1'b0, "clean_miss_0x24");
        tests_run++;
        if (!(v_m[1] && t_m[1] == 3'd1)) begin
            tests_failed++; $display("FAIL clean_miss_line: got valid %0b tag %0d expected 1 1", v_m[1], t_m[1]);
        end
    endtask

    task automatic test_dirty_miss();
        set_line(1, 1'b1, 3'd1, 1'b1, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 32'h44, 2, 1'b0, "dirty_miss_0x44");
        tests_run++;
        if (mem_m[6'h09] !== 32'hDEAD_BEEF) begin
            tests_failed++; $display("FAIL dirty_miss_mem: got %0h expected deadbeef", mem_m[6'h09]);
        end
    endtask

    task automatic test_read_write_miss();
        set_line(3, 1'b1, 3'd5, 1'b0, 32'h0);
        access(1'b1, 1'b1, 32'h0C, 3, 1'b0, "rw_miss_0x0c");
    endtask

    task automatic test_drop();
        set_line(2, 1'b1, 3'd4, 1'b1, 32'hCAFE_F00D);
        access(1'b1, 1'b0, 32'h68, 2, 1'b1, "drop_mid_miss");
    endtask

    task automatic test_reset_mid_wb();
        logic [31:0] snap;
        set_line(1, 1'b1, 3'd1, 1'b1, 32'hDEAD_BEEF);
        snap = data_m[1];
        bus.read = 1'b0; bus.write = 1'b1; bus.address = 32'h44; bus.mem_BusyWait = 1'b1;
        drive_array();
        @(posedge clock); #1;
        tests_run++;
        if (bus.mem_Write !== 1'b1) begin
            tests_failed++; $display("FAIL rst_wb_enter: got mem_Write %0b expected 1", bus.mem_Write);
        end
        #2 reset = 1'b1;
        bus.mem_BusyWait = 1'b0;
        #1;
        tests_run++;
        if (bus.mem_Write !== 1'b0 || bus.mem_Read !== 1'b0 || bus.fill !== 1'b0 ||
            bus.mem_Address !== '0 || bus.mem_Writedata !== '0 || bus.busywait !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_async: got wr %0b rd %0b fill %0b addr %0h bw %0b expected 0 0 0 0 1",
                     bus.mem_Write, bus.mem_Read, bus.fill, bus.mem_Address, bus.busywait);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            tests_run++;
            if (bus.fill !== 1'b0 || bus.mem_Read !== 1'b0) begin
                tests_failed++; $display("FAIL rst_hold: got fill %0b rd %0b expected 0 0", bus.fill, bus.mem_Read);
            end
        end
        bus.write = 1'b0; bus.mem_BusyWait = 1'b1;
        reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if (bus.busywait !== 1'b0 || bus.mem_Write !== 1'b0 || bus.fill !== 1'b0) begin
            tests_failed++; $display("FAIL rst_release: got bw %0b wr %0b fill %0b expected 0 0 0", bus.busywait, bus.mem_Write, bus.fill);
        end
        // The line is untouched: the abandoned transaction never filled it.
        set_line(1, 1'b1, 3'd1, 1'b1, snap);
        access(1'b0, 1'b1, 32'h44, 1, 1'b0, "after_reset_retry");
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr;
        int op;
        for (int n = 0; n < 40; n++) begin
            addr      = $urandom;
            addr[7:5] = 3'($urandom_range(0, 2));
            op        = $urandom_range(0, 2);
            access(op != 1, op != 0, addr, $urandom_range(0, 3), ($urandom_range(0, 4) == 0), "random");
        end
    endtask

    initial begin
        for (int i = 0; i < NLINES; i++) set_line(i, 1'b0, 3'd0, 1'b0, 32'h0);
        for (int i = 0; i < NBLK; i++) mem_m[i] = $urandom;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = 32'h0; bus.mem_BusyWait = 1'b1;
        drive_array();
        test_reset();
        test_hit();
        test_clean_miss();
        test_dirty_miss();
        test_read_write_miss();
        test_drop();
        test_reset_mid_wb();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter TAG_W, default 3, meaning tag width (address[7:5]).
REQ-002 SHALL have parameter INDEX_W, default 3, meaning index width (address[4:2]).
REQ-003 SHALL have parameter DATA_W, default 32, meaning block/data width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE.
REQ-005 SHALL have these CPU-side ports:
- read  in  1  CPU read request.
- write  in  1  CPU write request.
- address  in  32  CPU byte address; only bits [7:2] are used.
- busywait  out  1  stall to CPU.
REQ-006 SHALL have these cache-array-side ports:
- entry_valid  in  1  valid bit of the indexed line.
- entry_tag  in  TAG_W  stored tag of the indexed line.
- dirty  in  1  dirty bit of the indexed line.
- evict_data  in  DATA_W  indexed line data, used for write-back.
- lookup_index  out  INDEX_W  address[4:2].
- hit  out  1  tag match AND valid.
- fill  out  1  one-cycle strobe: the array loads mem_Readdata, sets valid=1, dirty=0, tag=address[7:5].
REQ-007 SHALL have these memory-side ports:
- mem_Read  out  1  block read request.
- mem_Write  out  1  block write request.
- mem_Address  out  TAG_W+INDEX_W  block address {tag,index}.
- mem_Writedata  out  DATA_W  write-back data.
- mem_BusyWait  in  1  memory busy; low means the transfer is complete.

Function
REQ-008 SHALL compute hit combinationally as (entry_tag == address[7:5]) AND entry_valid.
REQ-009 SHALL implement a three-state FSM: IDLE, MEM_READ, WRITE_BACK.
REQ-010 SHALL, in IDLE, go to WRITE_BACK when (read|write) & !hit & dirty; go to MEM_READ when (read|write) & !hit & !dirty; otherwise stay in IDLE.
REQ-011 SHALL, in WRITE_BACK, drive mem_Write=1, mem_Address={entry_tag,index}, mem_Writedata=evict_data, and go to MEM_READ on the first edge where mem_BusyWait=0.
REQ-012 SHALL, in MEM_READ, drive mem_Read=1 and mem_Address={address[7:5],index}, assert fill while mem_BusyWait=0, and return to IDLE on that edge.
REQ-013 SHALL drive busywait = (state!=IDLE) | ((read|write) & !hit); on a hit in IDLE, busywait=0 with zero added latency.
REQ-014 SHALL drive outputs as Moore functions of state, except hit, busywait and fill; in IDLE, mem_Read=mem_Write=0 and mem_Address=mem_Writedata=0.
REQ-015 SHALL never assert mem_Read and mem_Write together.
REQ-016 SHALL treat read&write together as a single access; the requester holds address stable while busywait=1.
REQ-017 SHALL, when a request drops mid-miss, still complete the current memory transaction before returning to IDLE.
REQ-018 SHALL produce a miss latency of 1 IDLE edge plus the memory cycles; a clean miss resolves in IDLE as a hit one cycle after fill.

Reset
REQ-019 SHALL, on reset assertion, immediately enter IDLE, with mem_Read=mem_Write=0, mem_Address=0, mem_Writedata=0 and fill=0; busywait follows REQ-013.
REQ-020 SHALL, when reset asserts mid-transaction, abandon the transaction with no fill pulse.

Structure
REQ-021 SHALL place state encoding (IDLE=0, MEM_READ=1, WRITE_BACK=2) and the TAG_W/INDEX_W/DATA_W defaults in a shared package, cache_pkg.
REQ-022 SHALL contain one sub-module, tag_hit_unit (equality comparator ANDed with valid); the FSM is inline.

Verification
REQ-023 Read, address=0x24, entry_tag=1, entry_valid=1 -> hit=1, busywait=0, state stays IDLE, no mem request.
REQ-024 Read 0x24, entry_valid=0, dirty=0 -> MEM_READ, mem_Read=1, mem_Address=0x09; memory busy 5 cycles then low -> one fill pulse, IDLE, then hit=1.
REQ-025 Write 0x44, entry_tag=1, dirty=1, evict_data=0xDEADBEEF -> WRITE_BACK, mem_Write=1, mem_Address=0x09, mem_Writedata=0xDEADBEEF; then MEM_READ with mem_Address=0x11.
REQ-026 Reset asserted in WRITE_BACK -> IDLE asynchronously, mem_Write=0, no fill.
REQ-027 Read and write both high on a miss -> exactly one MEM_READ sequence; mem_Read and mem_Write are never high together.
